// File: rtl/tty_tx_if.sv
// Teleprinter channel bus: CPU-side strobes and character in, serial line and status out.
interface tty_tx_if;
  logic       load;
  logic       clear_flag;
  logic [7:0] data_in;
  logic       tx;
  logic       busy;
  logic       print_flag;

  modport master (
    output load,
    output clear_flag,
    output data_in,
    input  tx,
    input  busy,
    input  print_flag
  );

  modport slave (
    input  load,
    input  clear_flag,
    input  data_in,
    output tx,
    output busy,
    output print_flag
  );
endinterface

// File: rtl/tty_tx.sv
// PDP-8 teleprinter output channel: TLS character to 8N1 serial frame, LSB first, plus printer flag.
// Optional macro TTY_STOP2_EN: two stop bits (ASR-33 timing) instead of one.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | line high, waiting for a TLS load
// START | start bit (tx=0) for one bit time
// DATA  | eight data bits, shift[0] on the line, LSB first
// STOP  | stop bit(s) high; flag sets on the final edge
module tty_tx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic     clock,
  input  logic     reset,
  tty_tx_if.slave  bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
`ifdef TTY_STOP2_EN
  localparam int STOP_CLKS = 2 * CLKS_PER_BIT;
`else
  localparam int STOP_CLKS = CLKS_PER_BIT;
`endif
  localparam int CNT_W = $clog2(2 * CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             tx_r, tx_n;
  logic             busy_r, busy_n;
  logic             flag_r, flag_n;
  logic             bit_end;
  logic             stop_end;

  assign bit_end  = (baud_cnt == BIT_LAST);
  assign stop_end = (baud_cnt == STOP_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
      flag_r   <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      tx_r     <= tx_n;
      busy_r   <= busy_n;
      flag_r   <= flag_n;
    end
  end

  // tx is registered so the UART pin never sees decode glitches.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    tx_n       = tx_r;
    busy_n     = busy_r;
    flag_n     = flag_r;

    if (bus.clear_flag) flag_n = 1'b0;

    case (state)
      IDLE: begin
        tx_n       = 1'b1;
        busy_n     = 1'b0;
        baud_cnt_n = '0;
        if (bus.load) begin
          shift_n   = bus.data_in;
          bit_idx_n = '0;
          tx_n      = 1'b0;
          busy_n    = 1'b1;
          flag_n    = 1'b0;
          state_n   = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          tx_n       = shift[0];
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          shift_n    = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shift[1];
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (stop_end) begin
          // Completion overrides a same-cycle clear so a finished character is never lost.
          baud_cnt_n = '0;
          tx_n       = 1'b1;
          busy_n     = 1'b0;
          flag_n     = 1'b1;
          state_n    = IDLE;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_n    = IDLE;
        baud_cnt_n = '0;
        tx_n       = 1'b1;
        busy_n     = 1'b0;
      end
    endcase
  end

  assign bus.tx         = tx_r;
  assign bus.busy       = busy_r;
  assign bus.print_flag = flag_r;

endmodule

// File: tb/tb_tty_tx.sv
// Scoreboard bench for tty_tx: frame-position reference model predicts tx/busy/print_flag per cycle.
module tb_tty_tx;

  localparam int CPB = 10;
`ifdef TTY_STOP2_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif
  localparam int FRAME = (9 + NSTOP) * CPB;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  tty_tx_if ifc ();

  tty_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  typedef struct {
    logic tx;
    logic busy;
    logic flag;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model: position within the current frame (-1 when idle) and the frame's bit list.
  int          m_pos   = -1;
  logic        m_flag  = 1'b0;
  logic [10:0] m_frame = '1;

  function automatic void check(string nm, logic got, logic want, int c);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s cycle=%0d got=%b expected=%b", nm, c, got, want);
  endfunction

  task automatic drive(input logic r, input logic l, input logic c, input logic [7:0] d);
    exp_t e;
    reset          = r;
    ifc.load       = l;
    ifc.clear_flag = c;
    ifc.data_in    = d;
    @(posedge clock);
    cyc++;
    if (r) begin
      m_pos  = -1;
      m_flag = 1'b0;
    end else if (m_pos >= 0) begin
      if (m_pos == FRAME - 1) begin
        m_pos  = -1;
        m_flag = 1'b1;
      end else begin
        m_pos++;
        if (c) m_flag = 1'b0;
      end
    end else if (l) begin
      m_pos   = 0;
      m_frame = {2'b11, d, 1'b0};
      m_flag  = 1'b0;
    end else if (c) begin
      m_flag = 1'b0;
    end
    e.tx   = (m_pos < 0) ? 1'b1 : m_frame[m_pos / CPB];
    e.busy = (m_pos >= 0);
    e.flag = m_flag;
    e.cyc  = cyc;
    q.push_back(e);
    #1;
    reset          = 1'b0;
    ifc.load       = 1'b0;
    ifc.clear_flag = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] d);
    drive(1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic wait_pos(input int p);
    int budget = 2 * FRAME;
    while (m_pos != p && budget > 0) begin
      idle(1);
      budget--;
    end
    if (m_pos != p) begin
      n_checks++;
      $display("FAIL wait_pos model position=%0d expected=%0d", m_pos, p);
    end
  endtask

  task automatic wait_idle();
    int budget = FRAME + 5;
    while (m_pos >= 0 && budget > 0) begin
      idle(1);
      budget--;
    end
  endtask

  // Monitor: one expected sample per clock, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("tx", ifc.tx, e.tx, e.cyc);
        check("busy", ifc.busy, e.busy, e.cyc);
        check("print_flag", ifc.print_flag, e.flag, e.cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b1;
    ifc.load       = 1'b0;
    ifc.clear_flag = 1'b0;
    ifc.data_in    = 8'h00;

    repeat (3) drive(1'b1, 1'b0, 1'b0, 8'h00);
    idle(50);

    send(8'hC1);
    wait_idle();
    idle(5);

    send(8'h55);
    wait_pos(35);
    drive(1'b0, 1'b1, 1'b0, 8'hFF);
    wait_idle();
    idle(3);

    send(8'($urandom));
    wait_pos(FRAME - 1);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    idle(3);

    send(8'($urandom));
    wait_pos(4 * CPB + 5);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    idle(3);
    send(8'h0D);
    wait_idle();
    idle(5);

    drive(1'b0, 1'b1, 1'b1, 8'hA5);
    wait_idle();
    idle(3);

    send(8'h8D);
    wait_idle();
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 599) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 24) == 0),
            8'($urandom));
    end
    wait_idle();
    idle(3);

    repeat (2) @(negedge clock);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain pending=%0d expected=0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
